// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache: 64 lines x 4 words in front of a word-addressed memory.
// Misses are served by an optional 4-word write-back of the victim line, then a 4-word refill.
module cache_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic        rd,
  input  logic [31:0] addr_req,
  input  logic [31:0] data_wr,
  output logic [31:0] data_rd,
  output logic [31:0] addr_resp,
  output logic        rdy,
  output logic        busy,
  output logic        wr_mem,
  output logic        rd_mem,
  input  logic        busy_mem,
  input  logic [31:0] data_rd_mem,
  output logic [31:0] data_wr_mem,
  output logic [31:0] addr_mem,
  output logic [31:0] cache_miss_count,
  output logic [31:0] cache_hit_count
);

  localparam int unsigned LINES  = 64;
  localparam int unsigned WORDS  = 4;
  localparam int unsigned TAG_W  = 22;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned WORD_W = 2;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t state, state_d;

  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [DATA_W-1:0] data_arr [LINES*WORDS];
  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WORD_W-1:0] req_word;
  logic              req;
  logic              hit;

  logic [TAG_W-1:0]  miss_tag;
  logic [IDX_W-1:0]  miss_idx;
  logic [WORD_W-1:0] word_cnt;
  logic [WORD_W-1:0] word_nxt;
  logic              refill_done;

  logic              accept;
  logic              start_miss;
  logic              step;
  logic              refill_last;
  logic              wr_mem_d;
  logic              rd_mem_d;
  logic [31:0]       addr_mem_d;
  logic [31:0]       data_wr_mem_d;

  assign req_tag     = addr_req[31:10];
  assign req_idx     = addr_req[9:4];
  assign req_word    = addr_req[3:2];
  assign req         = wr | rd;
  assign hit         = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign word_nxt    = word_cnt + 2'd1;
  assign refill_last = (state == REFILL) && step && (word_cnt == 2'd3);

  // Next state, handshake decode and next values of the registered memory-side outputs.
  always_comb begin
    state_d       = state;
    accept        = 1'b0;
    start_miss    = 1'b0;
    step          = 1'b0;
    busy          = 1'b0;
    wr_mem_d      = wr_mem;
    rd_mem_d      = rd_mem;
    addr_mem_d    = addr_mem;
    data_wr_mem_d = data_wr_mem;
    case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            accept = 1'b1;
          end else begin
            busy       = 1'b1;
            start_miss = 1'b1;
            if (valid[req_idx] && dirty[req_idx]) begin
              state_d       = WRITEBACK;
              wr_mem_d      = 1'b1;
              addr_mem_d    = {tag_arr[req_idx], req_idx, 2'b00, 2'b00};
              data_wr_mem_d = data_arr[{req_idx, 2'b00}];
            end else begin
              state_d    = REFILL;
              rd_mem_d   = 1'b1;
              addr_mem_d = {req_tag, req_idx, 2'b00, 2'b00};
            end
          end
        end
      end
      WRITEBACK: begin
        busy = 1'b1;
        if (!busy_mem) begin
          step = 1'b1;
          if (word_cnt == 2'd3) begin
            state_d    = REFILL;
            wr_mem_d   = 1'b0;
            rd_mem_d   = 1'b1;
            addr_mem_d = {miss_tag, miss_idx, 2'b00, 2'b00};
          end else begin
            addr_mem_d    = {tag_arr[miss_idx], miss_idx, word_nxt, 2'b00};
            data_wr_mem_d = data_arr[{miss_idx, word_nxt}];
          end
        end
      end
      REFILL: begin
        busy = 1'b1;
        if (!busy_mem) begin
          step = 1'b1;
          if (word_cnt == 2'd3) begin
            state_d  = IDLE;
            rd_mem_d = 1'b0;
          end else begin
            addr_mem_d = {miss_tag, miss_idx, word_nxt, 2'b00};
          end
        end
      end
      default: begin
        state_d  = IDLE;
        wr_mem_d = 1'b0;
        rd_mem_d = 1'b0;
      end
    endcase
  end

  // Control state, line status bits, responses and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      word_cnt         <= '0;
      wr_mem           <= 1'b0;
      rd_mem           <= 1'b0;
      addr_mem         <= '0;
      data_wr_mem      <= '0;
      rdy              <= 1'b0;
      data_rd          <= '0;
      addr_resp        <= '0;
      valid            <= '0;
      dirty            <= '0;
      cache_miss_count <= '0;
      cache_hit_count  <= '0;
      refill_done      <= 1'b0;
      miss_tag         <= '0;
      miss_idx         <= '0;
    end else begin
      state       <= state_d;
      wr_mem      <= wr_mem_d;
      rd_mem      <= rd_mem_d;
      addr_mem    <= addr_mem_d;
      data_wr_mem <= data_wr_mem_d;
      rdy         <= accept;
      if (start_miss) begin
        word_cnt         <= '0;
        miss_tag         <= req_tag;
        miss_idx         <= req_idx;
        cache_miss_count <= cache_miss_count + 32'd1;
      end else if (step) begin
        word_cnt <= word_nxt;
      end
      if (accept) begin
        addr_resp   <= addr_req;
        refill_done <= 1'b0;
        if (!refill_done) begin
          cache_hit_count <= cache_hit_count + 32'd1;
        end
        if (wr) begin
          dirty[req_idx] <= 1'b1;
        end else begin
          data_rd <= data_arr[{req_idx, req_word}];
        end
      end
      if (refill_last) begin
        valid[miss_idx] <= 1'b1;
        dirty[miss_idx] <= 1'b0;
        refill_done     <= 1'b1;
      end
    end
  end

  // Tag and data storage; validity is carried by the reset-cleared valid bits.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      data_arr[{req_idx, req_word}] <= data_wr;
    end
    if ((state == REFILL) && step) begin
      data_arr[{miss_idx, word_cnt}] <= data_rd_mem;
    end
    if (refill_last) begin
      tag_arr[miss_idx] <= miss_tag;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: transaction-level cache model, memory model, per-cycle bus/response checker.
module tb_cache_controller;

  logic        clk;
  logic        rst;
  logic        wr;
  logic        rd;
  logic [31:0] addr_req;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic [31:0] addr_resp;
  logic        rdy;
  logic        busy;
  logic        wr_mem;
  logic        rd_mem;
  logic        busy_mem = 1'b0;
  logic [31:0] data_rd_mem = 32'h0;
  logic [31:0] data_wr_mem;
  logic [31:0] addr_mem;
  logic [31:0] miss_cnt;
  logic [31:0] hit_cnt;

  cache_controller dut (
    .clk(clk), .rst(rst), .wr(wr), .rd(rd), .addr_req(addr_req), .data_wr(data_wr),
    .data_rd(data_rd), .addr_resp(addr_resp), .rdy(rdy), .busy(busy),
    .wr_mem(wr_mem), .rd_mem(rd_mem), .busy_mem(busy_mem), .data_rd_mem(data_rd_mem),
    .data_wr_mem(data_wr_mem), .addr_mem(addr_mem),
    .cache_miss_count(miss_cnt), .cache_hit_count(hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %h expected none (t=%0t)", name, act, $time);
  endtask

  // Backing memory (what the bus sees) and the CPU-visible memory image.
  logic [31:0] bus_mem [4096];
  logic [31:0] cpu_mem [4096];
  bit          mem_init_done = 1'b0;

  // Cache occupancy model: which tag sits in each set and whether it holds unwritten data.
  logic        m_valid [64];
  logic        m_dirty [64];
  logic [21:0] m_tag   [64];
  int unsigned m_miss;
  int unsigned m_hit;
  logic [31:0] m_last_rd;

  typedef struct {logic is_wr; logic [31:0] addr; logic [31:0] data;} xfer_t;
  typedef struct {logic [31:0] addr; logic [31:0] data;} resp_t;
  xfer_t xq[$];
  xfer_t xlog[$];
  resp_t rq[$];

  int stall_arm  = 0;
  int stall_used = 0;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    for (int i = 0; i < 4096; i++) cpu_mem[i] = bus_mem[i];
    m_miss    = 0;
    m_hit     = 0;
    m_last_rd = 32'h0;
    xq.delete();
    rq.delete();
  endtask

  // Predict bus traffic, response and latency of one CPU access.
  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              output int lat);
    int          idx;
    logic [21:0] t;
    logic [31:0] ba;
    idx = int'(a[9:4]);
    t   = a[31:10];
    lat = 1;
    if (!(m_valid[idx] && m_tag[idx] == t)) begin
      m_miss++;
      lat = 6;
      if (m_valid[idx] && m_dirty[idx]) begin
        lat = 10;
        for (int k = 0; k < 4; k++) begin
          ba = {m_tag[idx], 6'(idx), 2'(k), 2'b00};
          xq.push_back('{1'b1, ba, cpu_mem[ba[13:2]]});
        end
      end
      for (int k = 0; k < 4; k++) begin
        ba = {t, 6'(idx), 2'(k), 2'b00};
        xq.push_back('{1'b0, ba, 32'h0});
      end
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = t;
    end else begin
      m_hit++;
    end
    if (w) begin
      cpu_mem[a[13:2]] = d;
      m_dirty[idx]     = 1'b1;
    end else begin
      m_last_rd = cpu_mem[a[13:2]];
    end
    rq.push_back('{a, m_last_rd});
  endtask

  // Memory: answers reads on the falling edge, commits writes that are not stalled.
  always @(negedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 4096; i++) bus_mem[i] = 32'h5A00_0000 | 32'(i);
      bus_mem[12'h040] = 32'hDEAD_BEEF;
      bus_mem[12'h0C1] = 32'h0BAD_F00D;
      mem_init_done = 1'b1;
    end
    if (rd_mem) data_rd_mem = bus_mem[addr_mem[13:2]];
    if (wr_mem && !busy_mem && !rst) bus_mem[addr_mem[13:2]] = data_wr_mem;
  end

  // Memory stall generator: holds busy_mem while refilling word 1 when armed.
  always @(posedge clk) begin
    #2;
    if (stall_used < stall_arm && rd_mem && addr_mem[3:2] == 2'd1) begin
      busy_mem = 1'b1;
      stall_used++;
    end else begin
      busy_mem = 1'b0;
    end
  end

  // Per-cycle checker of memory transfers and CPU responses against the model.
  always @(negedge clk) begin
    xfer_t x;
    resp_t r;
    if (!rst) begin
      if (wr_mem || rd_mem) begin
        check("strobe_excl", 32'(wr_mem & rd_mem), 32'h0);
        if (!busy_mem) begin
          xlog.push_back('{wr_mem, addr_mem, data_wr_mem});
          if (xq.size() == 0) begin
            fail_now("unexpected_xfer", addr_mem);
          end else begin
            x = xq.pop_front();
            check("xfer_kind", 32'(wr_mem), 32'(x.is_wr));
            check("xfer_addr", addr_mem, x.addr);
            if (x.is_wr) check("wb_data", data_wr_mem, x.data);
          end
        end
      end
      if (rdy) begin
        if (rq.size() == 0) begin
          fail_now("unexpected_rdy", addr_resp);
        end else begin
          r = rq.pop_front();
          check("addr_resp", addr_resp, r.addr);
          check("data_rd", data_rd, r.data);
        end
      end
    end
  end

  task automatic do_req(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input int stall, output int lat);
    int exp_lat;
    model_access(w, a, d, exp_lat);
    exp_lat += stall;
    if (stall > 0) stall_arm = stall_used + stall;
    @(negedge clk);
    wr = w; rd = r; addr_req = a; data_wr = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rdy && lat < 100);
    if (!rdy) fail_now("rdy_timeout", a);
    check("latency", 32'(lat), 32'(exp_lat));
    check("miss_count", miss_cnt, 32'(m_miss));
    check("hit_count", hit_cnt, 32'(m_hit));
    @(negedge clk);
    wr = 1'b0; rd = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; wr = 1'b0; rd = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr_req = '0; data_wr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", 32'(rdy), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_wr_mem", 32'(wr_mem), 32'h0);
    check("rst_rd_mem", 32'(rd_mem), 32'h0);
    check("rst_data_rd", data_rd, 32'h0);
    check("rst_addr_resp", addr_resp, 32'h0);
    check("rst_addr_mem", addr_mem, 32'h0);
    check("rst_data_wr_mem", data_wr_mem, 32'h0);
    check("rst_miss", miss_cnt, 32'h0);
    check("rst_hit", hit_cnt, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Cold read miss with a clean refill.
    xlog.delete();
    do_req(1'b0, 1'b1, 32'h100, 32'h0, 0, lat);
    check("cold_lat", 32'(lat), 32'd6);
    check("cold_data", data_rd, 32'hDEAD_BEEF);
    check("cold_miss", miss_cnt, 32'd1);
    check("cold_hit", hit_cnt, 32'd0);
    check("cold_nxfer", 32'(xlog.size()), 32'd4);
    if (xlog.size() == 4) begin
      check("cold_rd0_addr", xlog[0].addr, 32'h100);
      check("cold_rd3_addr", xlog[3].addr, 32'h10C);
    end

    // Dirty victim: write 0x0, then read 0x400 in the same set.
    xlog.delete();
    do_req(1'b1, 1'b0, 32'h0, 32'h11, 0, lat);
    do_req(1'b0, 1'b1, 32'h400, 32'h0, 0, lat);
    check("wb_lat", 32'(lat), 32'd10);
    check("wb_nxfer", 32'(xlog.size()), 32'd12);
    if (xlog.size() == 12) begin
      check("wb0_kind", 32'(xlog[4].is_wr), 32'd1);
      check("wb0_addr", xlog[4].addr, 32'h0);
      check("wb0_data", xlog[4].data, 32'h11);
      check("wb3_addr", xlog[7].addr, 32'hC);
      check("rf0_addr", xlog[8].addr, 32'h400);
      check("rf3_addr", xlog[11].addr, 32'h40C);
    end
    check("rf_data", data_rd, 32'h5A00_0100);

    // Simultaneous wr and rd on a hit: write wins, data_rd holds.
    do_req(1'b0, 1'b1, 32'h0, 32'h0, 0, lat);
    check("reload_data", data_rd, 32'h11);
    do_req(1'b1, 1'b1, 32'h8, 32'hCAFE_F00D, 0, lat);
    check("wr_prio_lat", 32'(lat), 32'd1);
    check("wr_prio_hold", data_rd, 32'h11);
    check("wr_prio_resp", addr_resp, 32'h8);
    do_req(1'b0, 1'b1, 32'h8, 32'h0, 0, lat);
    check("wr_prio_data", data_rd, 32'hCAFE_F00D);

    // Memory stall of 3 cycles in the middle of a refill.
    do_req(1'b0, 1'b1, 32'h304, 32'h0, 3, lat);
    check("stall_lat", 32'(lat), 32'd9);
    check("stall_data", data_rd, 32'h0BAD_F00D);

    // Reset in the middle of a refill, then the same address misses again.
    model_access(1'b0, 32'h200, 32'h0, lat);
    @(negedge clk);
    rd = 1'b1; addr_req = 32'h200;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rd_mem && n < 20);
    if (!rd_mem) fail_now("refill_start_timeout", addr_mem);
    @(posedge clk); #1;
    rst = 1'b1; rd = 1'b0;
    #1;
    check("abort_rd_mem", 32'(rd_mem), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, 1'b1, 32'h200, 32'h0, 0, lat);
    check("post_rst_lat", 32'(lat), 32'd6);
    check("post_rst_miss", miss_cnt, 32'd1);
    check("post_rst_hit", hit_cnt, 32'd0);
    check("post_rst_data", data_rd, 32'h5A00_0080);

    // Fill the whole cache by writes, then read every word back.
    do_reset();
    for (int k = 0; k < 256; k++) do_req(1'b1, 1'b0, 32'(4 * k), 32'(k), 0, lat);
    for (int k = 0; k < 256; k++) begin
      do_req(1'b0, 1'b1, 32'(4 * k), 32'h0, 0, lat);
      if (k == 255) check("sweep_last", data_rd, 32'd255);
    end
    check("sweep_miss", miss_cnt, 32'd64);
    check("sweep_hit", hit_cnt, 32'd448);

    repeat (3) @(negedge clk);
    check("xq_drained", 32'(xq.size()), 32'h0);
    check("rq_drained", 32'(rq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
